chinx_pcctrl: RTL and testbench

//  Next-PC controller that drives the IF stage's PC-select inputs: bsrc_o, epc_o, ipc_o and rpc_o.
//  - Arbitrates each cycle between stall, branch, interrupt entry and return-from-interrupt.
//  - Latches and prioritises interrupt requests and saves the return address.
//  - Sequences a single-level interrupt service: IDLE -> ISR -> GUARD.

---
 rtl/chinx_pcctrl.sv | 103 ++++++++++
 tb/tb_chinx_pcctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/chinx_pcctrl.sv
// chinx_pcctrl: next-PC select and single-level interrupt sequencer beside the IF stage.
// Define CHINX_IRQ_VEC_EN for per-source vectors (VEC_BASE + k); otherwise all IRQs share VEC_BASE.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module chinx_pcctrl #(
    parameter int unsigned   AW       = `ADDR_WIDTH,
    parameter int unsigned   NIRQ     = 4,
    parameter logic [AW-1:0] VEC_BASE = 'h10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   pc_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic            iret_i,
    input  logic            ien_i,
    input  logic [NIRQ-1:0] irq_i,
    output logic [2:0]      bsrc_o,
    output logic [AW-1:0]   epc_o,
    output logic [AW-1:0]   ipc_o,
    output logic [AW-1:0]   rpc_o,
    output logic [NIRQ-1:0] irq_ack_o,
    output logic [2:0]      irq_id_o,
    output logic            in_isr_o
);

    typedef enum logic [1:0] {StIdle, StIsr, StGuard} state_e;

    state_e          state_q, state_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] irq_s_q, irq_h_q;
    logic [NIRQ-1:0] rise, ack;
    logic [AW-1:0]   rpc_q;
    logic [2:0]      irq_id_q, sel;
    logic            take;

    // History resets to all-ones so lines held high through reset do not look like new edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            pend_q   <= '0;
            irq_s_q  <= '1;
            irq_h_q  <= '1;
            rpc_q    <= '0;
            irq_id_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            irq_s_q <= irq_i;
            irq_h_q <= irq_s_q;
            if (take) begin
                rpc_q    <= pc_i + AW'(1);
                irq_id_q <= sel;
            end
        end
    end

    always_comb begin
        rise = irq_s_q & ~irq_h_q;
        sel  = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (pend_q[k]) sel = 3'(k);
        end

        take = (state_q == StIdle) && ien_i && (|pend_q) && !stall_i && !branch_i && !iret_i;

        ack = '0;
        for (int k = 0; k < NIRQ; k++) begin
            ack[k] = take && (sel == 3'(k));
        end
        // A fresh edge in the ack cycle re-arms the bit.
        pend_d = (pend_q & ~ack) | rise;

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (take) state_d = StIsr;
            StIsr:   if (iret_i && !stall_i) state_d = StGuard;
            StGuard: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        bsrc_o = 3'd0;
        if (stall_i)                              bsrc_o = 3'd2;
        else if (iret_i && (state_q == StIsr))    bsrc_o = 3'd4;
        else if (branch_i)                        bsrc_o = 3'd1;
        else if (take)                            bsrc_o = 3'd3;
    end

`ifdef CHINX_IRQ_VEC_EN
    assign ipc_o = VEC_BASE + AW'(sel);
`else
    assign ipc_o = VEC_BASE;
`endif

    assign epc_o     = pc_i;
    assign rpc_o     = rpc_q;
    assign irq_ack_o = ack;
    assign irq_id_o  = irq_id_q;
    assign in_isr_o  = (state_q == StIsr);

endmodule

// File: tb/tb_chinx_pcctrl.sv
// Table-driven bench for chinx_pcctrl: per-cycle vectors go through an expectation queue.
// Expected ipc follows CHINX_IRQ_VEC_EN the same way the design build does.
module tb_chinx_pcctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        stall_i, branch_i, iret_i, ien_i;
    logic [3:0]  irq_i;
    logic [2:0]  bsrc_o;
    logic [31:0] epc_o, ipc_o, rpc_o;
    logic [3:0]  irq_ack_o;
    logic [2:0]  irq_id_o;
    logic        in_isr_o;

    int tests = 0;
    int fails = 0;

    chinx_pcctrl dut (
        .clk       (clk),
        .rst       (rst),
        .pc_i      (pc_i),
        .stall_i   (stall_i),
        .branch_i  (branch_i),
        .iret_i    (iret_i),
        .ien_i     (ien_i),
        .irq_i     (irq_i),
        .bsrc_o    (bsrc_o),
        .epc_o     (epc_o),
        .ipc_o     (ipc_o),
        .rpc_o     (rpc_o),
        .irq_ack_o (irq_ack_o),
        .irq_id_o  (irq_id_o),
        .in_isr_o  (in_isr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  irq;
        logic [3:0]  ctl;   // {ien, stall, branch, iret}
        logic [31:0] pc;
        logic [2:0]  bsrc;
        logic [3:0]  ack;
        logic        isr;
        logic [31:0] rpc;
        logic [2:0]  id;
        logic [2:0]  k;     // source whose vector is expected when bsrc==3
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic add(input logic [3:0] irq, input logic [3:0] ctl, input logic [31:0] pc,
                       input logic [2:0] bsrc, input logic [3:0] ack, input logic isr,
                       input logic [31:0] rpc, input logic [2:0] id, input logic [2:0] k);
        vec_t v;
        v.irq = irq; v.ctl = ctl; v.pc = pc; v.bsrc = bsrc; v.ack = ack;
        v.isr = isr; v.rpc = rpc; v.id = id; v.k = k;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
        end
    endtask

    // Called at posedge+1: drive, queue expectation, compare at negedge, advance one edge.
    task automatic run_vec(input int row, input vec_t v);
        vec_t e;
        logic [31:0] exp_ipc;
        irq_i = v.irq;
        {ien_i, stall_i, branch_i, iret_i} = v.ctl;
        pc_i = v.pc;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
`ifdef CHINX_IRQ_VEC_EN
        exp_ipc = 32'h10 + 32'(e.k);
`else
        exp_ipc = 32'h10;
`endif
        chk("bsrc", row, 32'(bsrc_o), 32'(e.bsrc));
        chk("ack", row, 32'(irq_ack_o), 32'(e.ack));
        chk("in_isr", row, 32'(in_isr_o), 32'(e.isr));
        chk("rpc", row, rpc_o, e.rpc);
        chk("irq_id", row, 32'(irq_id_o), 32'(e.id));
        chk("epc", row, epc_o, e.pc);
        if (e.bsrc == 3'd3) chk("ipc", row, ipc_o, exp_ipc);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] P = 32'h40;

    initial begin
        vec_t v;
        // Reset held with every line high; release must not create pending bits.
        add(4'hF, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h0,  3'd0, 3'd0);
        add(4'hF, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h0,  3'd0, 3'd0);
        add(4'hF, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h0,  3'd0, 3'd0);
        add(4'h0, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h0,  3'd0, 3'd0);
        add(4'h0, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h0,  3'd0, 3'd0);
        // Entry on IRQ2, then stalled iret, iret, guard.
        add(4'h4, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h0,  3'd0, 3'd0);
        add(4'h4, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h0,  3'd0, 3'd0);
        add(4'h4, 4'b1000, P, 3'd3, 4'h4, 1'b0, 32'h0,  3'd0, 3'd2);
        add(4'h4, 4'b1000, P, 3'd0, 4'h0, 1'b1, 32'h41, 3'd2, 3'd0);
        add(4'h4, 4'b1101, P, 3'd2, 4'h0, 1'b1, 32'h41, 3'd2, 3'd0);
        add(4'h4, 4'b1101, P, 3'd2, 4'h0, 1'b1, 32'h41, 3'd2, 3'd0);
        add(4'h4, 4'b1001, P, 3'd4, 4'h0, 1'b1, 32'h41, 3'd2, 3'd0);
        add(4'h4, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd2, 3'd0);
        add(4'h0, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd2, 3'd0);
        // IRQ3 and IRQ1 together: IRQ1 first, IRQ3 after the guard cycle.
        add(4'hA, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd2, 3'd0);
        add(4'hA, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd2, 3'd0);
        add(4'hA, 4'b1000, P, 3'd3, 4'h2, 1'b0, 32'h41, 3'd2, 3'd1);
        add(4'hA, 4'b1000, P, 3'd0, 4'h0, 1'b1, 32'h41, 3'd1, 3'd0);
        add(4'hA, 4'b1001, P, 3'd4, 4'h0, 1'b1, 32'h41, 3'd1, 3'd0);
        add(4'hA, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd1, 3'd0);
        add(4'hA, 4'b1000, P, 3'd3, 4'h8, 1'b0, 32'h41, 3'd1, 3'd3);
        add(4'hA, 4'b1000, P, 3'd0, 4'h0, 1'b1, 32'h41, 3'd3, 3'd0);
        add(4'hA, 4'b1001, P, 3'd4, 4'h0, 1'b1, 32'h41, 3'd3, 3'd0);
        add(4'hA, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd3, 3'd0);
        add(4'h0, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd3, 3'd0);
        // Stall and branch both beat entry; iret outside ISR is ignored.
        add(4'h1, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd3, 3'd0);
        add(4'h1, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd3, 3'd0);
        add(4'h1, 4'b1100, 32'h77, 3'd2, 4'h0, 1'b0, 32'h41, 3'd3, 3'd0);
        add(4'h1, 4'b1010, P, 3'd1, 4'h0, 1'b0, 32'h41, 3'd3, 3'd0);
        add(4'h1, 4'b1000, P, 3'd3, 4'h1, 1'b0, 32'h41, 3'd3, 3'd0);
        add(4'h1, 4'b1000, P, 3'd0, 4'h0, 1'b1, 32'h41, 3'd0, 3'd0);
        add(4'h1, 4'b1001, P, 3'd4, 4'h0, 1'b1, 32'h41, 3'd0, 3'd0);
        add(4'h1, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd0, 3'd0);
        add(4'h1, 4'b1001, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd0, 3'd0);
        add(4'h0, 4'b1000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd0, 3'd0);
        // ien gates entry; take at PC 0xFFFFFFFF wraps the return address.
        add(4'h1, 4'b0000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd0, 3'd0);
        add(4'h1, 4'b0000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd0, 3'd0);
        add(4'h1, 4'b0000, P, 3'd0, 4'h0, 1'b0, 32'h41, 3'd0, 3'd0);
        add(4'h1, 4'b1000, 32'hFFFF_FFFF, 3'd3, 4'h1, 1'b0, 32'h41, 3'd0, 3'd0);
        add(4'h1, 4'b1000, P, 3'd0, 4'h0, 1'b1, 32'h0,  3'd0, 3'd0);
        add(4'h3, 4'b1000, P, 3'd0, 4'h0, 1'b1, 32'h0,  3'd0, 3'd0);
        add(4'h3, 4'b1000, P, 3'd0, 4'h0, 1'b1, 32'h0,  3'd0, 3'd0);

        rst = 1'b0; irq_i = 4'hF; pc_i = P;
        ien_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; iret_i = 1'b0;
        #12;
        chk("rst_bsrc", -1, 32'(bsrc_o), 32'd0);
        chk("rst_ack", -1, 32'(irq_ack_o), 32'd0);
        chk("rst_isr", -1, 32'(in_isr_o), 32'd0);
        chk("rst_rpc", -1, rpc_o, 32'd0);
        chk("rst_id", -1, 32'(irq_id_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Asynchronous reset mid-service: clears at once, and the latched IRQ1 is lost.
        #3 rst = 1'b0;
        #1;
        chk("arst_isr", -2, 32'(in_isr_o), 32'd0);
        chk("arst_rpc", -2, rpc_o, 32'd0);
        chk("arst_id", -2, 32'(irq_id_o), 32'd0);
        chk("arst_ack", -2, 32'(irq_ack_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        v.irq = 4'h3; v.ctl = 4'b1000; v.pc = P; v.bsrc = 3'd0; v.ack = 4'h0;
        v.isr = 1'b0; v.rpc = 32'h0; v.id = 3'd0; v.k = 3'd0;
        for (int i = 0; i < 4; i++) run_vec(100 + i, v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
